// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline latch: owns the PC, issues imem reads and
// presents the latched instruction to decode. Supports stall, redirect and sticky halt.
module fetch_stage #(
    parameter logic [31:0] PCINIT   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  InstrOp,
    output logic [5:0]  InstrFunc,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_npc,
    output logic [31:0] fetch_count
);

    localparam logic [0:0] StRun    = 1'b0;
    localparam logic [0:0] StHalted = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] inpc_q, inpc_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        inpc_d  = inpc_q;
        fcnt_d  = fcnt_q;
        // HALTED freezes everything, so only RUN has work to do.
        if (state_q == StRun) begin
            if (halt) begin
                state_d = StHalted;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end else if (redirect) begin
                pc_d    = {redirect_addr[31:2], 2'b00};
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end else if (stall) begin
                // Hold; a concurrent ihit word is dropped and refetched.
            end else if (ihit) begin
                instr_d = imemload;
                valid_d = 1'b1;
                ipc_d   = pc_q;
                inpc_d  = pc_plus4;
                pc_d    = pc_plus4;
                fcnt_d  = fcnt_q + 32'd1;
            end else begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StRun;
            pc_q    <= PCINIT;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            ipc_q   <= 32'h0;
            inpc_q  <= 32'h0;
            fcnt_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            inpc_q  <= inpc_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign imemaddr    = pc_q;
    assign imemREN     = (state_q == StRun);
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign InstrOp     = instr_q[31:26];
    assign InstrFunc   = instr_q[5:0];
    assign instr_pc    = ipc_q;
    assign instr_npc   = inpc_q;
    assign fetch_count = fcnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline latch of the pipelined MIPS core. Sits directly upstream of the decode/control unit.
- Owns the PC and issues instruction-memory reads.
- Presents the latched instruction, its opcode/funct fields, and PC/PC+4 to decode.
- Accepts stall, flush/redirect and halt from downstream.

Parameters:
- PCINIT, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- CLK  input  1  clock, all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- ihit  input  1  instruction memory returns imemload for imemaddr this cycle.
- imemload  input  32  instruction word from instruction memory.
- imemREN  output  1  instruction read enable.
- imemaddr  output  32  fetch address (current PC).
- stall  input  1  hazard unit holds the IF/ID latch and PC.
- redirect  input  1  taken branch/jump resolved in decode; flush IF/ID and reload PC.
- redirect_addr  input  32  target PC for redirect.
- halt  input  1  decode has seen HALT; stop fetching permanently until reset.
- instr  output  32  latched instruction (IF/ID).
- instr_valid  output  1  instr is a real fetched instruction, not a bubble.
- InstrOp  output  6  instr[31:26], feeds control unit opcode.
- InstrFunc  output  6  instr[5:0], feeds control unit funct.
- instr_pc  output  32  PC of latched instruction.
- instr_npc  output  32  instr_pc + 4.
- fetch_count  output  32  number of instructions delivered to IF/ID since reset.

Behaviour:
- Registers: pc, IF/ID latch {instr, instr_valid, instr_pc, instr_npc}, state, fetch_count.
- FSM states: RUN, HALTED. Reset enters RUN.
  - RUN -> HALTED when halt=1 on a clock edge.
  - HALTED is sticky; only RST leaves it.
- Reset values:
  - pc=PCINIT; state=RUN.
  - instr=NOP_WORD, instr_valid=0, instr_pc=0, instr_npc=0.
  - fetch_count=0.
- imemaddr = pc (combinational). imemREN = 1 in RUN, 0 in HALTED.
- InstrOp/InstrFunc are combinational slices of the latched instr.
- Per-edge priority in RUN (highest first):
  1. RST: reset values above, regardless of any other input.
  2. halt: state<=HALTED, pc held, IF/ID <= bubble (instr=NOP_WORD, valid=0).
  3. redirect: pc <= {redirect_addr[31:2],2'b00}. IF/ID <= bubble. The ihit word in the same cycle is discarded. Redirect overrides stall.
  4. stall: pc and IF/ID hold their values. An ihit in the same cycle is dropped and refetched later (pc does not advance).
  5. ihit:
     - instr<=imemload, instr_valid<=1, instr_pc<=pc, instr_npc<=pc+4.
     - pc<=pc+4; fetch_count<=fetch_count+1.
  6. else (waiting on memory): pc held, IF/ID <= bubble.
- HALTED: pc, IF/ID bubble and fetch_count frozen. ihit, stall and redirect are ignored.
- Latency: an instruction appears in IF/ID one edge after its ihit cycle (stall=0, redirect=0).
- Arithmetic:
  - pc+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- Redirect while ihit=0 abandons the outstanding read. The next imemaddr is the new target the following cycle.
- RST asserted mid-stall or mid-wait: all state is reset on that edge. A held instruction is lost.

Test Plan:
- Reset and sequential fetch: RST=1 for 2 cycles, release; ihit=1 every cycle, imemload=32'h2001_0005 then 32'h2002_0007 -> imemaddr 0,4,8. Next edge after the first ihit: instr=32'h2001_0005, InstrOp=6'h08, instr_pc=0, instr_npc=4, valid=1, fetch_count=1.
- Memory wait: ihit=0 for 3 cycles at pc=8 -> imemaddr stays 8, instr_valid=0 and instr=0 on each of those edges. ihit=1 -> pc=12, valid=1.
- Stall hold: latched instr at pc=4; stall=1 for 2 cycles with ihit=1 -> instr/instr_pc unchanged, imemaddr stays 8, fetch_count unchanged. Release -> 8 is fetched.
- Redirect precedence: stall=1, ihit=1, redirect=1, redirect_addr=32'h0000_0103 -> next edge pc=32'h0000_0100, instr_valid=0, fetch_count unchanged.
- Halt: halt=1 at pc=32'h20 -> imemREN=0 next cycle. pc stays 32'h20 for 10 cycles despite ihit/redirect toggling. RST=1 -> pc=PCINIT, imemREN=1.
- Wrap: redirect to 32'hFFFF_FFFC, then ihit=1 -> instr_npc=0, pc=0.
